// File: rtl/conv_controller_pkg.sv
// Shared definitions for the convolution sequencer: pipeline depth, default
// widths, FSM state encoding and the credit helper.
package conv_ctrl_pkg;

    // Operand register plus five datapath stages: accept edge to result ready.
    localparam int PIPE_DEPTH     = 6;

    localparam int DEF_DATA_W     = 128;
    localparam int DEF_RES_W      = 21;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } conv_state_e;

    // Number of windows currently travelling through the datapath stages.
    function automatic logic [3:0] vld_popcount(input logic [PIPE_DEPTH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/conv_controller_if.sv
// Bundle of job control, window stream, datapath drive and result stream for
// conv_controller. master = controller side, slave = environment side.
interface conv_controller_if
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RES_W  = DEF_RES_W,
    parameter int CNT_W  = DEF_CNT_W
);
    // Job control
    logic                     start;
    logic [CNT_W-1:0]         num_windows;
    logic                     busy;
    logic                     done;

    // Window operand stream
    logic                     win_valid;
    logic                     win_ready;
    logic [DATA_W-1:0]        win_data_in;
    logic [DATA_W-1:0]        win_filter_in;

    // Datapath drive and return
    logic [DATA_W-1:0]        dp_input_matrix;
    logic [DATA_W-1:0]        dp_filter_matrix;
    logic                     dp_mul_enable;
    logic                     dp_l1_enable;
    logic                     dp_l2_enable;
    logic                     dp_l3_enable;
    logic                     dp_l4_enable;
    logic signed [RES_W-1:0]  dp_conv_out;

    // Result stream
    logic                     res_valid;
    logic                     res_ready;
    logic signed [RES_W-1:0]  res_data;
    logic                     res_last;

    modport master (
        input  start, num_windows, win_valid, win_data_in, win_filter_in,
               dp_conv_out, res_ready,
        output busy, done, win_ready, dp_input_matrix, dp_filter_matrix,
               dp_mul_enable, dp_l1_enable, dp_l2_enable, dp_l3_enable,
               dp_l4_enable, res_valid, res_data, res_last
    );

    modport slave (
        output start, num_windows, win_valid, win_data_in, win_filter_in,
               dp_conv_out, res_ready,
        input  busy, done, win_ready, dp_input_matrix, dp_filter_matrix,
               dp_mul_enable, dp_l1_enable, dp_l2_enable, dp_l3_enable,
               dp_l4_enable, res_valid, res_data, res_last
    );

endinterface

// File: rtl/conv_res_fifo.sv
// Result FIFO for conv_controller: synchronous, first-word-fall-through head,
// occupancy count output, asynchronous active-low reset. The head reads as 0
// while empty so the result outputs are quiet between jobs and after reset.
module conv_res_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Storage array; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/conv_controller.sv
// Sequencer for the 16-tap convolution datapath. Accepts windows over a
// valid/ready stream, drives operand registers and per-stage enables one
// window per cycle, and buffers results in a FIFO so downstream backpressure
// never stalls the datapath. Credit-based admission guarantees every window
// in flight has a FIFO slot waiting for it.
// Optional build macro CONV_RELU_EN: negative results are clamped to 0
// before they enter the FIFO.
module conv_controller
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RES_W      = DEF_RES_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    conv_controller_if.master bus
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] FEED  = ST_FEED;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W  = $clog2(FIFO_DEPTH + PIPE_DEPTH + 1);

    logic [1:0]              state;
    logic [CNT_W-1:0]        job_len;
    logic [CNT_W-1:0]        win_accepted;
    logic                    done_q;

    logic [DATA_W-1:0]       input_q;
    logic [DATA_W-1:0]       filter_q;
    logic [PIPE_DEPTH-1:0]   vld_p;
    logic [PIPE_DEPTH-1:0]   last_p;

    logic                    accept;
    logic                    accept_last;
    logic                    win_ready_c;
    logic [CRD_W-1:0]        credit_used;

    logic                    push;
    logic                    pop;
    logic                    res_valid_c;
    logic signed [RES_W-1:0] push_res;
    logic [RES_W:0]          fifo_head;
    logic [FCNT_W-1:0]       fifo_count;

`ifdef CONV_RELU_EN
    function automatic logic signed [RES_W-1:0] relu_clip(input logic signed [RES_W-1:0] x);
        return x[RES_W-1] ? '0 : x;
    endfunction

    assign push_res = relu_clip(bus.dp_conv_out);
`else
    assign push_res = bus.dp_conv_out;
`endif

    // Every window in the stages or in the FIFO holds a reserved slot.
    assign credit_used = CRD_W'(fifo_count) + CRD_W'(vld_popcount(vld_p));
    assign win_ready_c = (state == FEED) && (credit_used < CRD_W'(FIFO_DEPTH));
    assign accept      = bus.win_valid && win_ready_c;
    assign accept_last = accept && (win_accepted == job_len - CNT_W'(1));

    assign res_valid_c = (fifo_count != '0);
    assign pop         = res_valid_c && bus.res_ready;
    assign push        = vld_p[PIPE_DEPTH-1];

    // Job sequencing: count accepts, drain until the tagged last result leaves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            job_len      <= '0;
            win_accepted <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.num_windows != '0) begin
                            state        <= FEED;
                            job_len      <= bus.num_windows;
                            win_accepted <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (accept) begin
                        win_accepted <= win_accepted + CNT_W'(1);
                        if (accept_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_head[RES_W]) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand registers capture on accept and otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            input_q  <= '0;
            filter_q <= '0;
        end else if (accept) begin
            input_q  <= bus.win_data_in;
            filter_q <= bus.win_filter_in;
        end
    end

    // Valid/last tags advance every cycle; the datapath cannot stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p  <= {vld_p[PIPE_DEPTH-2:0], accept};
            last_p <= {last_p[PIPE_DEPTH-2:0], accept_last};
        end
    end

    conv_res_fifo #(
        .WIDTH (RES_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({last_p[PIPE_DEPTH-1], push_res}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bus.busy             = (state != IDLE);
    assign bus.done             = done_q;
    assign bus.win_ready        = win_ready_c;
    assign bus.dp_input_matrix  = input_q;
    assign bus.dp_filter_matrix = filter_q;
    assign bus.dp_mul_enable    = vld_p[0];
    assign bus.dp_l1_enable     = vld_p[1];
    assign bus.dp_l2_enable     = vld_p[2];
    assign bus.dp_l3_enable     = vld_p[3];
    assign bus.dp_l4_enable     = vld_p[4];
    assign bus.res_valid        = res_valid_c;
    assign bus.res_data         = $signed(fifo_head[RES_W-1:0]);
    assign bus.res_last         = fifo_head[RES_W];

endmodule

// File: tb/tb_conv_controller.sv
// Self-checking bench for conv_controller with a behavioural datapath and a
// transaction-level reference model (expected-result queue, job bookkeeping).
// Build with or without CONV_RELU_EN; expectations follow the same macro.
module tb_conv_controller;
    import conv_ctrl_pkg::*;

    localparam int DATA_W     = 128;
    localparam int RES_W      = 21;
    localparam int CNT_W      = 16;
    localparam int FIFO_DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conv_controller_if #(.DATA_W(DATA_W), .RES_W(RES_W), .CNT_W(CNT_W)) bus ();

    conv_controller #(
        .DATA_W     (DATA_W),
        .RES_W      (RES_W),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int now    = 0;

    always @(posedge clk) now <= now + 1;

    // Signed 16-lane dot product of 8-bit lanes.
    function automatic logic signed [RES_W-1:0] ref_dot(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b);
        int acc;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            acc += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
        end
        return RES_W'(acc);
    endfunction

    function automatic logic signed [RES_W-1:0] ref_result(input logic [DATA_W-1:0] a,
                                                           input logic [DATA_W-1:0] b);
        logic signed [RES_W-1:0] d;
        d = ref_dot(a, b);
`ifdef CONV_RELU_EN
        if (d < 0) d = '0;
`endif
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural datapath: products, four adder levels, output register.
    logic signed [RES_W-1:0] dp_s1 = '0, dp_s2 = '0, dp_s3 = '0, dp_s4 = '0, dp_out = '0;
    always @(posedge clk) begin
        if (bus.dp_mul_enable) dp_s1 <= ref_dot(bus.dp_input_matrix, bus.dp_filter_matrix);
        if (bus.dp_l1_enable)  dp_s2 <= dp_s1;
        if (bus.dp_l2_enable)  dp_s3 <= dp_s2;
        if (bus.dp_l3_enable)  dp_s4 <= dp_s3;
        if (bus.dp_l4_enable)  dp_out <= dp_s4;
    end
    assign bus.dp_conv_out = dp_out;

    // Reference model state
    typedef struct {
        logic signed [RES_W-1:0] data;
        bit                      last;
        int                      rdy;
    } exp_t;

    exp_t              q[$];
    bit                acc_at[int];
    bit                m_busy  = 1'b0;
    bit                m_done  = 1'b0;
    int                m_total = 0;
    int                m_acc   = 0;
    logic [DATA_W-1:0] m_in    = '0;
    logic [DATA_W-1:0] m_fi    = '0;
    bit                obs_ready;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        acc_at.delete();
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_total = 0;
        m_acc   = 0;
        m_in    = '0;
        m_fi    = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      bus.busy,             0);
        check({tag, "_done"},      bus.done,             0);
        check({tag, "_win_ready"}, bus.win_ready,        0);
        check({tag, "_res_valid"}, bus.res_valid,        0);
        check({tag, "_res_data"},  {107'd0, bus.res_data}, 0);
        check({tag, "_res_last"},  bus.res_last,         0);
        check({tag, "_dp_in"},     bus.dp_input_matrix,  0);
        check({tag, "_dp_filt"},   bus.dp_filter_matrix, 0);
        check({tag, "_enables"},   {bus.dp_mul_enable, bus.dp_l1_enable, bus.dp_l2_enable,
                                    bus.dp_l3_enable, bus.dp_l4_enable}, 0);
    endtask

    // One clock: observe outputs against the model at the falling edge, drive
    // the next inputs, then advance the model to the state after the next rise.
    task automatic step(input bit st, input int nw, input bit wv, input bit rr,
                        input logic [DATA_W-1:0] pa, input logic [DATA_W-1:0] fi);
        bit   exp_valid, exp_ready, was_busy, acc;
        exp_t e;
        @(negedge clk);
        exp_valid = (q.size() > 0) && (q[0].rdy <= now);
        exp_ready = m_busy && (m_acc < m_total) && (q.size() < FIFO_DEPTH);
        was_busy  = m_busy;
        obs_ready = bus.win_ready;

        check("busy",      bus.busy,      m_busy);
        check("done",      bus.done,      m_done);
        check("win_ready", bus.win_ready, exp_ready);
        check("res_valid", bus.res_valid, exp_valid);
        if (exp_valid) begin
            check("res_data", {107'd0, bus.res_data}, {107'd0, q[0].data});
            check("res_last", bus.res_last, q[0].last);
        end
        check("dp_input",  bus.dp_input_matrix,  m_in);
        check("dp_filter", bus.dp_filter_matrix, m_fi);
        check("mul_en", bus.dp_mul_enable, acc_at.exists(now));
        check("l1_en",  bus.dp_l1_enable,  acc_at.exists(now - 1));
        check("l2_en",  bus.dp_l2_enable,  acc_at.exists(now - 2));
        check("l3_en",  bus.dp_l3_enable,  acc_at.exists(now - 3));
        check("l4_en",  bus.dp_l4_enable,  acc_at.exists(now - 4));

        bus.start         = st;
        bus.num_windows   = CNT_W'(nw);
        bus.win_valid     = wv;
        bus.win_data_in   = pa;
        bus.win_filter_in = fi;
        bus.res_ready     = rr;

        m_done = 1'b0;
        acc    = wv && exp_ready;
        if (exp_valid && rr) begin
            if (q[0].last) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
            void'(q.pop_front());
        end
        if (acc) begin
            e.data = ref_result(pa, fi);
            e.last = (m_acc == m_total - 1);
            e.rdy  = now + 1 + PIPE_DEPTH;
            q.push_back(e);
            m_acc++;
            m_in = pa;
            m_fi = fi;
            acc_at[now + 1] = 1'b1;
        end
        if (!was_busy && st) begin
            if (nw != 0) begin
                m_busy  = 1'b1;
                m_total = nw;
                m_acc   = 0;
            end else begin
                m_done = 1'b1;
            end
        end
    endtask

    // Run the current job to completion with randomised valid/ready activity
    // and occasional (ignored) start pulses, then observe the done cycle.
    task automatic drain_job(input int wv_pct, input int rr_pct, input bit fixed,
                             input logic [DATA_W-1:0] pa, input logic [DATA_W-1:0] fi);
        int guard;
        guard = 0;
        while (m_busy && guard < 3000) begin
            step(($urandom_range(0, 15) == 0), int'($urandom_range(0, 30)),
                 ($urandom_range(0, 99) < wv_pct), ($urandom_range(0, 99) < rr_pct),
                 fixed ? pa : rand128(), fixed ? fi : rand128());
            guard++;
        end
        check("job_timeout", (guard >= 3000), 0);
        step(0, 0, 0, 1, '0, '0);
        step(0, 0, 0, 1, '0, '0);
    endtask

    task automatic run_job(input int n, input int wv_pct, input int rr_pct, input bit fixed,
                           input logic [DATA_W-1:0] pa, input logic [DATA_W-1:0] fi);
        step(1, n, 0, 1, '0, '0);
        drain_job(wv_pct, rr_pct, fixed, pa, fi);
    endtask

    logic [DATA_W-1:0] ones_v;
    logic [DATA_W-1:0] relu_pa;
    logic [DATA_W-1:0] relu_fi;
    int                stall_cnt;

    initial begin
        bus.start         = 1'b0;
        bus.num_windows   = '0;
        bus.win_valid     = 1'b0;
        bus.win_data_in   = '0;
        bus.win_filter_in = '0;
        bus.res_ready     = 1'b0;

        ones_v  = '1;
        relu_fi = '0;
        for (int i = 0; i < 16; i++) relu_fi[8*i +: 8] = 8'h01;
        relu_pa = '1;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Single window of all-ones operands: result 16, last tag, done
        run_job(1, 100, 100, 1'b1, ones_v, ones_v);

        // Twenty back-to-back windows with free-flowing output
        run_job(20, 100, 100, 1'b0, '0, '0);

        // Output blocked: admission stops after FIFO_DEPTH windows
        step(1, 20, 0, 0, '0, '0);
        stall_cnt = 0;
        repeat (20) begin
            step(0, 0, 1, 0, rand128(), rand128());
            if (obs_ready) stall_cnt++;
        end
        check("stall_accepts", stall_cnt, FIFO_DEPTH);
        drain_job(100, 100, 1'b0, '0, '0);

        // Zero-length job: done only
        step(1, 0, 1, 1, rand128(), rand128());
        step(0, 0, 1, 1, rand128(), rand128());
        step(0, 0, 0, 1, '0, '0);

        // Reset with three windows in flight
        step(1, 10, 0, 1, '0, '0);
        repeat (3) step(0, 0, 1, 1, rand128(), rand128());
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        model_clear();
        repeat (3) step(0, 0, 1, 1, rand128(), rand128());
        reset = 1'b1;
        repeat (8) step(0, 0, 0, 1, '0, '0);
        run_job(5, 100, 100, 1'b0, '0, '0);

        // Negative result: clamped or passed through depending on the build
        run_job(1, 100, 100, 1'b1, relu_pa, relu_fi);

        // Randomised jobs with irregular valid/ready activity
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(1, 14)), 60, 55, 1'b0, '0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_controller.md
Name: conv_controller

Overview:
Sequencer for the 16-tap convolution datapath: multiplier array, four adder-tree levels and the output register.
- Accepts a job of N windows, each a 128-bit input patch plus a 128-bit filter, over a valid/ready handshake.
- Drives the datapath operand registers and the per-stage enables as a fully pipelined stream, one window per cycle.
- Captures each conv result into a small result FIFO with valid/ready output, so downstream backpressure never corrupts the non-stallable datapath.

Parameters:
DATA_W, 128, width of input patch and filter buses (16 x 8-bit).
RES_W, 21, width of the datapath conv result (two's complement).
CNT_W, 16, width of window-count fields.
FIFO_DEPTH, 8, result FIFO entries; must be >= PIPE_DEPTH (6).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  job start pulse; honoured only in IDLE
num_windows  in  CNT_W  windows in job; sampled on start
busy  out  1  high when state != IDLE
done  out  1  one-cycle pulse at job completion
win_valid  in  1  window operands valid
win_ready  out  1  controller can accept a window
win_data_in  in  DATA_W  input patch
win_filter_in  in  DATA_W  filter weights
dp_input_matrix  out  DATA_W  registered operand to datapath
dp_filter_matrix  out  DATA_W  registered operand to datapath
dp_mul_enable  out  1  multiplier stage enable
dp_l1_enable..dp_l4_enable  out  1 each  adder level enables
dp_conv_out  in  RES_W  datapath result
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer accepts head
res_data  out  RES_W  result
res_last  out  1  head is last window of job

Behaviour:
Reset (async, reset=0):
- State goes to IDLE.
- All outputs are 0, including operand registers and enables.
- The stage valid shift register, counters and FIFO are cleared.
- Reset mid-job discards in-flight and buffered results; no done pulse is produced.

FSM:
- IDLE: start with num_windows != 0 -> FEED, and the accepted/remaining counters load. start with num_windows == 0 -> done pulses on the next cycle and the state stays IDLE.
- FEED: the accept with accepted == num_windows-1 -> DRAIN.
- DRAIN: the pop (res_valid && res_ready && res_last) -> IDLE, with done pulsing in the cycle after the pop.
- start outside IDLE is ignored.

Pipeline (accept edge E0):
- Accept = win_valid && win_ready. Operand registers load at E0, and v[0] is set with a last tag.
- The valid/last shift register v[0..5] advances every cycle unconditionally.
- Enable mapping: dp_mul_enable = v[0], dp_l1_enable = v[1], ... dp_l4_enable = v[4].
- v[5] means dp_conv_out holds that window's result; it is pushed into the FIFO at E6.
- res_valid first rises after E6, giving a fixed latency of 6 cycles from the accept edge.
- Back-to-back accepts produce back-to-back results.
- Operand registers hold their last value when there is no accept.

Credit and FIFO:
- win_ready = (state == FEED) && (fifo_count + popcount(v) < FIFO_DEPTH).
- A push therefore never finds the FIFO full; overflow is impossible by construction.
- Push and pop in the same cycle leaves the count unchanged. Pop on an empty FIFO cannot occur.
- The last tag travels alongside its result.

Optional Feature:
CONV_RELU_EN
- Defined: a result with RES_W-1 set is replaced by 0 before the FIFO push (ReLU); the last tag is unaffected.
- Undefined: results pass through unmodified as signed values.

Decomposition:
- Package conv_ctrl_pkg holds the state enum (IDLE, FEED, DRAIN), localparam PIPE_DEPTH = 6, and default widths.
- One sub-module, conv_res_fifo: synchronous FIFO of RES_W+1 bits with count output, async active-low reset.

Test Plan:
- num_windows=1, all-ones patch x all-ones filter: res_data=16 exactly 6 cycles after accept, res_last=1, done pulses one cycle after the pop, busy falls.
- num_windows=20, win_valid held high, res_ready=1: 20 consecutive accepts and 20 consecutive results in order; only result 20 has res_last=1.
- num_windows=20, res_ready=0: win_ready drops after exactly 8 accepts and the FIFO fills to 8. Raising res_ready resumes accepts with no loss or duplication.
- start with num_windows=0: done pulses the next cycle, busy stays 0, win_ready stays 0.
- reset asserted with 3 windows in flight: all outputs are 0 immediately, no done, and a subsequent job runs correctly.
- CONV_RELU_EN with patch byte 0xFF x filter 0x01 (result -16 if signed): res_data=0 when defined, -16 in RES_W bits when undefined.
